fixed_point_slow_div: RTL and testbench

- Sequential signed fixed-point divider downstream of the fixed-point slow dot-product stage. It takes the dot result as the dividend and a second fixed-point value as the divisor, for perspective divide and normalisation.
- Computes one quotient bit per cycle using restoring division on magnitudes, then applies sign, saturation and flags in a final cycle.
- Same valid_in/valid_out style as the dot stage, plus a ready_out so the upstream stage knows when a new operation can be issued.

---
 rtl/fixed_point_slow_div.sv | 179 +++++++++++++++++
 tb/tb_fixed_point_slow_div.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_slow_div.sv
// Sequential signed fixed-point divider: one restoring-division bit per cycle on magnitudes,
// then a single cycle applying sign, saturation and divide-by-zero/overflow flags.
module fixed_point_slow_div #(
  parameter int N_WIDTH     = 32,
  parameter int N_FRAC_BITS = 14,
  parameter int D_WIDTH     = 32,
  parameter int D_FRAC_BITS = 14,
  parameter int Q_WIDTH     = 16,
  parameter int Q_FRAC_BITS = 14
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic signed [N_WIDTH-1:0] N,
  input  logic signed [D_WIDTH-1:0] D,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic                      valid_out,
  output logic signed [Q_WIDTH-1:0] Q,
  output logic                      div_zero,
  output logic                      overflow
);

  localparam int ShiftRaw = Q_FRAC_BITS + D_FRAC_BITS - N_FRAC_BITS;
  localparam int Shift    = (ShiftRaw < 0) ? 0 : ShiftRaw;
  localparam int W        = N_WIDTH + Shift;
  localparam int CntW     = $clog2(W);

  if (ShiftRaw < 0) begin : g_shift_err
    $error("fixed_point_slow_div: Q_FRAC_BITS + D_FRAC_BITS - N_FRAC_BITS must be >= 0");
  end
  if (W < Q_WIDTH) begin : g_width_err
    $error("fixed_point_slow_div: iteration count must not be below Q_WIDTH");
  end

  localparam logic [Q_WIDTH-1:0] MaxQ    = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] MinQ    = {1'b1, {(Q_WIDTH-1){1'b0}}};
  localparam logic [W-1:0]       PosMaxW = {{(W-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
  localparam logic [W-1:0]       NegMaxW = PosMaxW + W'(1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [W-1:0]        work_q, work_d;
  logic [D_WIDTH:0]    rem_q, rem_d;
  logic [D_WIDTH:0]    den_q, den_d;
  logic                sign_q, sign_d;
  logic                dz_q, dz_d;
  logic [Q_WIDTH-1:0]  q_q, q_d;
  logic                div_zero_q, div_zero_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;

  logic                accept;
  logic [N_WIDTH-1:0]  n_abs;
  logic [D_WIDTH-1:0]  d_abs;
  logic [D_WIDTH+1:0]  rem_shift;
  logic [D_WIDTH:0]    rem_diff;
  logic                rem_ge;
  logic [Q_WIDTH-1:0]  mag_lo;
  logic [Q_WIDTH-1:0]  sat_val;
  logic [Q_WIDTH-1:0]  res_q;
  logic                res_dz;
  logic                res_ov;
  logic                mag_over;

  // Unsigned magnitudes: the most negative input maps to 2^(width-1) without wrapping.
  assign n_abs = N[N_WIDTH-1] ? (~N + 1'b1) : N;
  assign d_abs = D[D_WIDTH-1] ? (~D + 1'b1) : D;

  assign rem_shift = {rem_q, work_q[W-1]};
  assign rem_ge    = rem_shift >= {1'b0, den_q};
  assign rem_diff  = rem_shift[D_WIDTH:0] - den_q;

  always_comb begin
    mag_lo   = work_q[Q_WIDTH-1:0];
    sat_val  = sign_q ? MinQ : MaxQ;
    mag_over = sign_q ? (work_q > NegMaxW) : (work_q > PosMaxW);
    res_dz   = 1'b0;
    res_ov   = 1'b0;
    res_q    = sign_q ? (~mag_lo + 1'b1) : mag_lo;
    if (dz_q) begin
      // With D == 0 the latched sign is simply the sign of N.
      res_q  = sat_val;
      res_dz = 1'b1;
    end else if (mag_over) begin
      res_q  = sat_val;
      res_ov = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    rem_d      = rem_q;
    den_d      = den_q;
    sign_d     = sign_q;
    dz_d       = dz_q;
    q_d        = q_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    ready_out  = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_out = 1'b1;
        accept    = valid_in;
      end
      StDiv: begin
        work_d = {work_q[W-2:0], rem_ge};
        rem_d  = rem_ge ? rem_diff : rem_shift[D_WIDTH:0];
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        ready_out  = 1'b1;
        accept     = valid_in;
        q_d        = res_q;
        div_zero_d = res_dz;
        overflow_d = res_ov;
        valid_d    = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An accept in StDone overlaps the result write with the next operation's load.
    if (accept) begin
      work_d  = W'(n_abs) << Shift;
      rem_d   = '0;
      den_d   = {1'b0, d_abs};
      sign_d  = N[N_WIDTH-1] ^ D[D_WIDTH-1];
      dz_d    = (D == '0);
      cnt_d   = CntW'(W - 1);
      state_d = StDiv;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_q     <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      q_q        <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      sign_q     <= sign_d;
      dz_q       <= dz_d;
      q_q        <= q_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign Q         = q_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_point_slow_div.sv
// Scoreboard bench for fixed_point_slow_div: requests push expected results computed with
// plain integer division; a negedge monitor pops and compares on every valid_out.
module tb_fixed_point_slow_div;

  localparam int SHIFT = 14;
  localparam int W     = 32 + SHIFT;
  localparam int LAT   = W + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_in = 1'b0;
  logic signed [31:0] n_in = '0;
  logic signed [31:0] d_in = '0;
  logic               ready_out;
  logic               valid_out;
  logic signed [15:0] q_out;
  logic               div_zero;
  logic               overflow;

  fixed_point_slow_div dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .N        (n_in),
    .D        (d_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .Q        (q_out),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] q;
    logic               dz;
    logic               ov;
    int                 exp_cyc;
    bit                 b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   last_acc = -1000;

  function automatic void chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: truncating division of |N|*2^SHIFT by |D|, then sign and saturation.
  function automatic exp_t model(input logic signed [31:0] n, input logic signed [31:0] d);
    exp_t   e;
    longint an, ad, mag, lim;
    bit     s;
    e.exp_cyc = 0;
    e.b2b     = 1'b0;
    e.dz      = 1'b0;
    e.ov      = 1'b0;
    an = (n < 0) ? -longint'(n) : longint'(n);
    ad = (d < 0) ? -longint'(d) : longint'(d);
    if (d == 0) begin
      e.dz = 1'b1;
      e.q  = (n < 0) ? 16'sh8000 : 16'sh7fff;
    end else begin
      s   = (n < 0) != (d < 0);
      mag = (an << SHIFT) / ad;
      lim = s ? 32768 : 32767;
      if (mag > lim) begin
        e.ov = 1'b1;
        e.q  = s ? 16'sh8000 : 16'sh7fff;
      end else begin
        e.q = 16'(s ? -mag : mag);
      end
    end
    return e;
  endfunction

  // Called at a negedge where the upcoming posedge accepts the request.
  function automatic void push(input logic signed [31:0] n, input logic signed [31:0] d);
    exp_t e;
    e         = model(n, d);
    e.exp_cyc = cyc + 1 + LAT;
    e.b2b     = (cyc + 1 == last_acc + LAT);
    last_acc  = cyc + 1;
    sb.push_back(e);
  endfunction

  function automatic logic signed [31:0] rnd();
    logic [31:0] v;
    if ($urandom_range(0, 15) == 0) return '0;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  // Waits for ready while toggling junk requests that must be ignored, then issues one.
  task automatic issue(input logic signed [31:0] n, input logic signed [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (!ready_out && guard < 4 * LAT) begin
      valid_in = ($urandom_range(0, 1) == 1);
      n_in     = $urandom;
      d_in     = $urandom;
      @(negedge clk);
      guard++;
    end
    if (!ready_out) begin
      chk("ready_timeout", 0, 1);
    end else begin
      valid_in = 1'b1;
      n_in     = n;
      d_in     = d;
      push(n, d);
    end
    @(negedge clk);
    valid_in = 1'b0;
    n_in     = $urandom;
    d_in     = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 4 * LAT) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compares results and checks outputs hold between pulses.
  logic signed [15:0] hold_q = '0;
  logic               hold_dz = 1'b0;
  logic               hold_ov = 1'b0;
  int                 last_valid = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q  = '0;
        hold_dz = 1'b0;
        hold_ov = 1'b0;
      end else if (valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.exp_cyc);
          chk("q", longint'(q_out), longint'(e.q));
          chk("div_zero", div_zero, e.dz);
          chk("overflow", overflow, e.ov);
          if (e.b2b) chk("b2b_gap", cyc - last_valid, LAT);
        end
        last_valid = cyc;
        hold_q     = q_out;
        hold_dz    = div_zero;
        hold_ov    = overflow;
      end else begin
        chk("hold_outputs", {q_out, div_zero, overflow}, {hold_q, hold_dz, hold_ov});
        if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
          chk("missing_valid", cyc, sb[0].exp_cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic signed [31:0] dir_n[10] = '{32'sd16384, -32'sd49152, 32'sd16384, -32'sd16384,
                                    32'sd16384, -32'sd16384, 32'sd65536, -32'sd65536,
                                    32'sh8000_0000, 32'sd0};
  logic signed [31:0] dir_d[10] = '{32'sd32768, 32'sd65536, 32'sd49152, 32'sd49152,
                                    32'sd0, 32'sd0, 32'sd16384, 32'sd16384,
                                    32'sh8000_0000, -32'sd5};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", ready_out, 1);
    chk("reset_valid", valid_out, 0);
    chk("reset_q", longint'(q_out), 0);
    chk("reset_flags", {div_zero, overflow}, 0);
    #1 rst_n = 1'b1;

    // Directed cases issued back to back.
    for (int i = 0; i < 10; i++) issue(dir_n[i], dir_d[i]);
    drain();

    for (int i = 0; i < 40; i++) issue(rnd(), rnd());
    drain();

    // valid_in held high with inputs changing every cycle.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      n_in     = rnd();
      d_in     = rnd();
      if (ready_out) push(n_in, d_in);
    end
    @(negedge clk);
    valid_in = 1'b0;
    drain();

    // Reset 20 cycles into an operation.
    issue(32'sd16384, 32'sd32768);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_q", longint'(q_out), 0);
    chk("midreset_valid", valid_out, 0);
    chk("midreset_ready", ready_out, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    issue(-32'sd49152, 32'sd65536);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
